// File: rtl/cim_mem_arbiter_pkg.sv
// Shared CiM types and constants for the temporary-result storage arbiter.
package cim_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    BUS_FSM                  = 3'd0,
    LOGIC_FSM                = 3'd1,
    DATA_FILL_FSM            = 3'd2,
    DENSE_BROADCAST_SAVE_FSM = 3'd3,
    MAC                      = 3'd4,
    LAYERNORM                = 3'd5,
    SOFTMAX                  = 3'd6
  } MEM_ACCESS_SRC_T;

  localparam int unsigned MEM_ACCESS_SRC_NUM = 7;
  localparam int unsigned TEMP_RES_ADDR_W    = 10;
  localparam int unsigned STORAGE_WORD_W     = 16;

  typedef logic [TEMP_RES_ADDR_W-1:0] TEMP_RES_ADDR_T;
  typedef logic [STORAGE_WORD_W-1:0]  STORAGE_WORD_T;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } ARB_STATE_T;

  localparam int unsigned ARB_LOCK_MAX   = 16;
  localparam int unsigned ARB_RD_LATENCY = 2;

endpackage

// File: rtl/cim_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr (with wrap).
module rr_pick #(
  parameter int unsigned N  = 7,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  logic [N-1:0] pool;
  logic         found;
  int unsigned  idx;

  always_comb begin
    // Excluded sources only win when nobody else is asking.
    pool   = ((req & ~excl) != '0) ? (req & ~excl) : req;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && pool[PW'(idx)]) begin
        found              = 1'b1;
        winner             = PW'(idx);
        grant[PW'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_mem_arbiter.sv
// Single-port arbiter for the CiM temporary-result storage: round-robin grants,
// bounded burst lock, registered memory command and read-return routing.
module cim_mem_arbiter
  import cim_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = MEM_ACCESS_SRC_NUM,
  parameter int unsigned RD_LATENCY = ARB_RD_LATENCY,
  parameter int unsigned LOCK_MAX   = ARB_LOCK_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            read_req_i,
  input  logic [NUM_SRC-1:0]            write_req_i,
  input  logic [NUM_SRC-1:0]            lock_i,
  input  TEMP_RES_ADDR_T [NUM_SRC-1:0]  addr_i,
  input  STORAGE_WORD_T  [NUM_SRC-1:0]  wdata_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output TEMP_RES_ADDR_T                mem_addr_o,
  output STORAGE_WORD_T                 mem_wdata_o,
  input  STORAGE_WORD_T                 mem_rdata_i,
  output logic [NUM_SRC-1:0]            rd_valid_o,
  output STORAGE_WORD_T                 rd_data_o,
  output logic                          busy_o
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  ARB_STATE_T         state, state_nxt;
  logic [SRC_W-1:0]   rr_ptr, owner, owner_nxt;
  logic [CNT_W-1:0]   lock_cnt, cnt_nxt;
  logic               excl_vld, excl_vld_nxt;
  logic [SRC_W-1:0]   excl_src, excl_src_nxt;

  logic [NUM_SRC-1:0] req, excl_mask, pick_grant;
  logic [SRC_W-1:0]   pick_src, gnt_src;
  logic               arb, gnt_vld, gnt_wr;

  logic                  cmd_rd;
  logic [SRC_W-1:0]      cmd_src;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [SRC_W-1:0]      tag_src [RD_LATENCY];

  assign req       = read_req_i | write_req_i;
  assign excl_mask = excl_vld ? (NUM_SRC'(1) << excl_src) : '0;

  rr_pick #(.N(NUM_SRC), .PW(SRC_W)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .excl   (excl_mask),
    .grant  (pick_grant),
    .winner (pick_src)
  );

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cnt_nxt      = lock_cnt;
    excl_vld_nxt = 1'b0;
    excl_src_nxt = excl_src;
    arb          = 1'b0;
    gnt_vld      = 1'b0;
    gnt_src      = pick_src;
    case (state)
      ARB_IDLE: arb = 1'b1;
      ARB_LOCKED: begin
        if (lock_cnt == CNT_W'(LOCK_MAX)) begin
          state_nxt    = ARB_IDLE;
          cnt_nxt      = '0;
          excl_vld_nxt = 1'b1;
          excl_src_nxt = owner;
        end else if (!lock_i[owner]) begin
          state_nxt = ARB_IDLE;
          cnt_nxt   = '0;
          arb       = 1'b1;
        end else begin
          // Idle lock cycles still count so the lock cannot block forever.
          cnt_nxt = lock_cnt + CNT_W'(1);
          if (req[owner]) begin
            gnt_vld = 1'b1;
            gnt_src = owner;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (arb && (pick_grant != '0)) begin
      gnt_vld = 1'b1;
      gnt_src = pick_src;
      if (lock_i[pick_src]) begin
        state_nxt = ARB_LOCKED;
        owner_nxt = pick_src;
        cnt_nxt   = CNT_W'(1);
      end
    end
    if (rst) gnt_vld = 1'b0;
  end

  assign grant_o = gnt_vld ? (NUM_SRC'(1) << gnt_src) : '0;
  assign gnt_wr  = write_req_i[gnt_src];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      lock_cnt    <= '0;
      excl_vld    <= 1'b0;
      excl_src    <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cmd_rd      <= 1'b0;
      cmd_src     <= '0;
      tag_vld     <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_src[i] <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
      excl_vld <= excl_vld_nxt;
      excl_src <= excl_src_nxt;
      if (gnt_vld) begin
        rr_ptr      <= (gnt_src == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_src + SRC_W'(1);
        mem_addr_o  <= addr_i[gnt_src];
        mem_wdata_o <= wdata_i[gnt_src];
      end
      mem_en_o <= gnt_vld;
      mem_we_o <= gnt_vld & gnt_wr;
      cmd_rd   <= gnt_vld & ~gnt_wr;
      cmd_src  <= gnt_src;
      // Tag pipe starts from the registered command so its tail lines up with mem_rdata_i.
      tag_vld[0] <= cmd_rd;
      tag_src[0] <= cmd_src;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  assign rd_valid_o = tag_vld[RD_LATENCY-1] ? (NUM_SRC'(1) << tag_src[RD_LATENCY-1]) : '0;
  assign rd_data_o  = tag_vld[RD_LATENCY-1] ? mem_rdata_i : '0;
  assign busy_o     = (state == ARB_LOCKED) | cmd_rd | (|tag_vld);

endmodule

// File: doc/cim_mem_arbiter.md
Name: cim_mem_arbiter

Overview:
- Arbitrates the CiM temporary-result storage's single memory port among all CiM access sources: BUS_FSM, LOGIC_FSM, DATA_FILL_FSM, DENSE_BROADCAST_SAVE_FSM, MAC, LAYERNORM and SOFTMAX.
- Issues at most one read or write per cycle to the storage macro.
- Routes each returning read word back to the source that issued it.
- Grants are round-robin; a bounded burst lock lets MAC/LAYERNORM/SOFTMAX stream without starving the others.

Parameters:
- NUM_SRC, MEM_ACCESS_SRC_NUM (7): number of requesters; index = MEM_ACCESS_SRC_T value.
- RD_LATENCY, 2: cycles from registered mem command to valid mem_rdata_i.
- LOCK_MAX, 16: maximum consecutive cycles one source may hold a lock.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- read_req_i  in  NUM_SRC  per-source read request, level, held until granted
- write_req_i  in  NUM_SRC  per-source write request, level, held until granted
- lock_i  in  NUM_SRC  per-source burst-lock request
- addr_i  in  NUM_SRC x TEMP_RES_ADDR_T  per-source address, stable while request high
- wdata_i  in  NUM_SRC x STORAGE_WORD_T  per-source write data
- grant_o  out  NUM_SRC  one-hot, combinational; request consumed this cycle
- mem_en_o  out  1  registered memory enable
- mem_we_o  out  1  registered write enable
- mem_addr_o  out  TEMP_RES_ADDR_T  registered address
- mem_wdata_o  out  STORAGE_WORD_T  registered write data
- mem_rdata_i  in  STORAGE_WORD_T  memory read data
- rd_valid_o  out  NUM_SRC  one-hot; rd_data_o is valid for that source
- rd_data_o  out  STORAGE_WORD_T  mem_rdata_i, broadcast to all sources
- busy_o  out  1  any read in flight, or state is ARB_LOCKED

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=ARB_IDLE; lock_cnt=0; read tag pipe cleared.
- Reset mid-operation: in-flight reads are discarded; no rd_valid_o after reset deasserts.

Requests and grants:
- req[s] = read_req_i[s] | write_req_i[s].
- grant_o is combinational from req, state, rr_ptr and lock_cnt; at most one bit is set.
- If a source raises read and write in the same cycle, the write is served first; the read stays pending and is served on a later grant.

State machine:
- ARB_IDLE: no req → no grant. Otherwise grant the first requester found searching upward (with wrap) from rr_ptr; then rr_ptr <= winner+1 mod NUM_SRC.
  - If lock_i[winner] is high at grant: go to ARB_LOCKED with owner=winner, lock_cnt=1.
- ARB_LOCKED: only owner may be granted.
  - Each cycle: lock_cnt++, whether or not owner requests (idle cycles count, so blocking is bounded).
  - Exit to ARB_IDLE when lock_i[owner] drops, or when lock_cnt==LOCK_MAX.
  - The exit cycle grants nothing if lock_cnt==LOCK_MAX; otherwise it arbitrates as ARB_IDLE.
  - After a LOCK_MAX exit, owner is excluded from the next IDLE arbitration if any other source requests.

Memory command and read return:
- On a grant in cycle N, register the memory command at N+1:
  - mem_en_o=1, mem_we_o=write_req_i[winner], mem_addr_o=addr_i[winner], mem_wdata_o=wdata_i[winner].
  - With no grant, mem_en_o=0; addr and data hold their last values.
- Read tag pipe: shift register of RD_LATENCY entries of {valid, src}.
  - rd_valid_o asserts at cycle N+1+RD_LATENCY for a read granted at N.
  - rd_data_o = mem_rdata_i in that cycle (combinational pass-through).
- Throughput: one grant per cycle, sustained back-to-back; reads pipeline fully with no bubbles.

Decomposition:
- MEM_ACCESS_SRC_T, TEMP_RES_ADDR_T and STORAGE_WORD_T come from the shared CiM package.
- New enum ARB_STATE_T {ARB_IDLE, ARB_LOCKED} is added to the shared CiM package.
- LOCK_MAX and RD_LATENCY defaults are added to the package as constants.
- One sub-module: rr_pick, a combinational round-robin priority picker (req, ptr, exclude mask → one-hot winner).

Test Plan:
- Reset, then MAC and SOFTMAX both hold read_req, addrs 0x10/0x20, rr_ptr=0 → grant MAC at N, SOFTMAX at N+1. mem_addr_o shows 0x10 at N+1 and 0x20 at N+2. rd_valid_o[MAC] at N+3, rd_valid_o[SOFTMAX] at N+4.
- All 7 sources request continuously for 14 cycles → each source granted exactly twice, in order 0..6,0..6; mem_en_o high for 14 consecutive cycles.
- LAYERNORM holds lock_i and read_req for 40 cycles while BUS_FSM also requests → LAYERNORM gets 16 grants, one no-grant cycle, then BUS_FSM granted, then LAYERNORM relocks.
- DATA_FILL_FSM asserts read_req and write_req together, addr 0x05, wdata 0xABCD → first grant gives mem_we_o=1 with data 0xABCD; second grant gives mem_we_o=0 to addr 0x05; rd_valid_o[DATA_FILL_FSM] 3 cycles after the second grant.
- Assert rst while two reads are in flight → all outputs 0 immediately; no rd_valid_o pulses afterwards; state=ARB_IDLE and rr_ptr=0 at first post-reset grant.
- Locked owner deasserts req but keeps lock_i high → no grants to others for the remaining cycles up to LOCK_MAX; busy_o stays 1 throughout; after release, arbitration resumes.
